// File: rtl/regfile_pkg.sv
// Shared types and constants for the register bank.
//   state_t        : sweep controller state (IDLE / SWEEP)
//   DEFAULT_WIDTH  : default word width in bits
//   DEFAULT_DEPTH  : default number of registers
//   ZERO_ADDR      : address of the hardwired-zero register
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 32;
  localparam int unsigned ZERO_ADDR     = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Clear-sweep controller: FSM, sweep index counter and busy register.
// Ports:
//   CLK      in  clock, rising edge
//   reset    in  asynchronous active-low reset
//   clearReq in  one-cycle request to start a sweep (ignored while sweeping)
//   clrEn    out high while sweeping; the register at clrAddr is cleared this edge
//   clrAddr  out register index cleared at the next edge (1..DEPTH-1)
//   busy     out high while a sweep is in progress
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          clearReq,
  output logic          clrEn,
  output logic [AW-1:0] clrAddr,
  output logic          busy
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;

  // State, index and busy registers; busy mirrors the next state so it is a flop.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= FIRST_IDX;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      busy  <= (state_nx == SWEEP);
    end
  end

  // Next-state and index logic.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (clearReq) begin
          state_nx = SWEEP;
          idx_nx   = FIRST_IDX;
        end
      end
      SWEEP: begin
        if (idx == LAST_IDX) begin
          state_nx = IDLE;
          idx_nx   = FIRST_IDX;
        end else begin
          idx_nx = idx + AW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = FIRST_IDX;
      end
    endcase
  end

  assign clrEn   = busy;
  assign clrAddr = idx;

endmodule

// File: rtl/regfile_bank.sv
// General-purpose register bank: DEPTH x WIDTH storage, one write port,
// two registered read ports, register 0 hardwired to zero, and a
// multi-cycle clear sweep driven by regfile_sweep_ctrl.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : same-edge write-through to a read port, and a read of the
//               register being cleared by the sweep returns 0
//   undefined : same-edge reads return the pre-edge register content
// Ports:
//   CLK       in  clock, rising edge
//   reset     in  asynchronous active-low reset
//   writeEn   in  write strobe
//   wAddr     in  write address
//   IN        in  write data
//   rAddrA/B  in  read addresses
//   OUTA/B    out registered read data
//   clearReq  in  start a clear sweep
//   busy      out clear sweep in progress
module regfile_bank
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             writeEn,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    rAddrA,
  input  logic [AW-1:0]    rAddrB,
  output logic [WIDTH-1:0] OUTA,
  output logic [WIDTH-1:0] OUTB,
  input  logic             clearReq,
  output logic             busy
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_ADDR);

  // Register 0 has no storage; entries 1..DEPTH-1 only.
  logic [WIDTH-1:0] mem [1:DEPTH-1];

  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic             wr_acc_c;
  logic [WIDTH-1:0] rd_a_c;
  logic [WIDTH-1:0] rd_b_c;

  regfile_sweep_ctrl #(
    .DEPTH (DEPTH)
  ) u_sweep_ctrl (
    .CLK      (CLK),
    .reset    (reset),
    .clearReq (clearReq),
    .clrEn    (clr_en),
    .clrAddr  (clr_addr),
    .busy     (busy)
  );

  // Writes are taken only when idle and never to register 0.
  assign wr_acc_c = writeEn && !clr_en && (wAddr != ZERO_A);

  // Storage: write port and sweep clear are mutually exclusive by construction.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (wr_acc_c) begin
      mem[wAddr] <= IN;
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end
  end

  // Read muxes, with optional same-edge forwarding of write/clear.
  always_comb begin
    rd_a_c = (rAddrA == ZERO_A) ? '0 : mem[rAddrA];
    rd_b_c = (rAddrB == ZERO_A) ? '0 : mem[rAddrB];
`ifdef REGFILE_BYPASS_EN
    if (wr_acc_c && (wAddr == rAddrA)) begin
      rd_a_c = IN;
    end else if (clr_en && (clr_addr == rAddrA)) begin
      rd_a_c = '0;
    end
    if (wr_acc_c && (wAddr == rAddrB)) begin
      rd_b_c = IN;
    end else if (clr_en && (clr_addr == rAddrB)) begin
      rd_b_c = '0;
    end
`endif
  end

  // Registered read outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      OUTA <= '0;
      OUTB <= '0;
    end else begin
      OUTA <= rd_a_c;
      OUTB <= rd_b_c;
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Scoreboard bench for regfile_bank (WIDTH=16, DEPTH=8).
module tb_regfile_bank;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK;
  logic        reset;
  logic        writeEn;
  logic [2:0]  wAddr;
  logic [15:0] IN;
  logic [2:0]  rAddrA;
  logic [2:0]  rAddrB;
  logic [15:0] OUTA;
  logic [15:0] OUTB;
  logic        clearReq;
  logic        busy;

  regfile_bank #(
    .WIDTH (16),
    .DEPTH (8)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .writeEn  (writeEn),
    .wAddr    (wAddr),
    .IN       (IN),
    .rAddrA   (rAddrA),
    .rAddrB   (rAddrB),
    .OUTA     (OUTA),
    .OUTB     (OUTB),
    .clearReq (clearReq),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // cyc = edge number after which the outputs must match; -1 = immediate check
  typedef struct packed {
    int          cyc;
    logic [95:0] nm;
    logic [15:0] a;
    logic [15:0] b;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  event sample_ev;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic push(input int cyc, input logic [95:0] nm,
                      input logic [15:0] a, input logic [15:0] b, input logic bz);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.a = a; e.b = b; e.bz = bz;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (OUTA !== e.a) begin
      failures++;
      $display("FAIL %0s OUTA got=%h want=%h edge=%0d", e.nm, OUTA, e.a, edge_cnt);
    end
    checks++;
    if (OUTB !== e.b) begin
      failures++;
      $display("FAIL %0s OUTB got=%h want=%h edge=%0d", e.nm, OUTB, e.b, edge_cnt);
    end
    checks++;
    if (busy !== e.bz) begin
      failures++;
      $display("FAIL %0s busy got=%b want=%b edge=%0d", e.nm, busy, e.bz, edge_cnt);
    end
  endtask

  // Monitor: edge-scheduled entries at the falling edge, immediate ones on demand.
  task automatic scan(input bit imm);
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == -1) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (!imm && sb[i].cyc == edge_cnt) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (!imm && sb[i].cyc < edge_cnt) begin
        checks++;
        failures++;
        $display("FAIL %0s stale expectation edge=%0d want_edge=%0d", sb[i].nm, edge_cnt, sb[i].cyc);
        sb.delete(i);
      end
    end
  endtask

  always @(negedge CLK) scan(1'b0);
  always @(sample_ev)   scan(1'b1);

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic exp_nx(input logic [95:0] nm, input logic [15:0] a,
                        input logic [15:0] b, input logic bz);
    push(edge_cnt + 1, nm, a, b, bz);
  endtask

  // Assert reset mid-cycle (after the falling-edge checks) and check outputs at once.
  task automatic async_reset_check(input logic [95:0] nm);
    @(negedge CLK);
    #1;
    reset = 1'b0;
    #1;
    push(-1, nm, 16'h0000, 16'h0000, 1'b0);
    ->sample_ev;
    #1;
  endtask

  task automatic read_all_zero(input logic [95:0] nm);
    for (int a = 0; a < 8; a++) begin
      rAddrA = 3'(a);
      rAddrB = 3'(7 - a);
      exp_nx(nm, 16'h0000, 16'h0000, 1'b0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired edge=%0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; writeEn = 1'b0; wAddr = '0; IN = '0;
    rAddrA = '0; rAddrB = '0; clearReq = 1'b0;

    // Held in reset
    tick();
    exp_nx("in_reset", 16'h0000, 16'h0000, 1'b0);
    tick();
    reset = 1'b1;

    // Basic write / read
    writeEn = 1'b1; wAddr = 3'd3; IN = 16'h001F;
    tick();
    wAddr = 3'd5; IN = 16'h0015;
    tick();
    writeEn = 1'b0; rAddrA = 3'd3; rAddrB = 3'd5;
    exp_nx("wr_rd", 16'h001F, 16'h0015, 1'b0);
    tick();

    // Register 0 stays zero
    writeEn = 1'b1; wAddr = 3'd0; IN = 16'hFFFF; rAddrA = 3'd0; rAddrB = 3'd0;
    exp_nx("r0_same", 16'h0000, 16'h0000, 1'b0);
    tick();
    writeEn = 1'b0; rAddrB = 3'd3;
    exp_nx("r0_read", 16'h0000, 16'h001F, 1'b0);
    tick();

    // Same-edge write and read
    writeEn = 1'b1; wAddr = 3'd2; IN = 16'h1234; rAddrA = 3'd3; rAddrB = 3'd5;
    exp_nx("pre_wr", 16'h001F, 16'h0015, 1'b0);
    tick();
    IN = 16'hABCD; rAddrA = 3'd2;
    exp_nx("same_edge", BYP ? 16'hABCD : 16'h1234, 16'h0015, 1'b0);
    tick();
    writeEn = 1'b0;
    exp_nx("after_wr", 16'hABCD, 16'h0015, 1'b0);
    tick();

    // Asynchronous reset while outputs are nonzero
    async_reset_check("async_rst");
    tick();
    reset = 1'b1;
    read_all_zero("rst_rd_all");

    // Clear sweep
    for (int i = 1; i < 8; i++) begin
      writeEn = 1'b1; wAddr = 3'(i); IN = 16'h1000 + 16'(i);
      tick();
    end
    writeEn = 1'b0; clearReq = 1'b1; rAddrA = 3'd7; rAddrB = 3'd1;
    exp_nx("sw_start", 16'h1007, 16'h1001, 1'b1);
    tick();
    clearReq = 1'b0;
    for (int m = 1; m < 8; m++) begin
      rAddrA   = 3'(m);
      rAddrB   = (m == 6) ? 3'd4 : 3'(m - 1);
      writeEn  = (m == 5);
      wAddr    = 3'd4;
      IN       = 16'hBEEF;
      clearReq = (m == 3);
      exp_nx("sweep", BYP ? 16'h0000 : 16'h1000 + 16'(m), 16'h0000, m < 7);
      tick();
    end
    writeEn = 1'b0; clearReq = 1'b0;
    read_all_zero("post_sweep");

    // Reset in the third busy cycle
    writeEn = 1'b1; wAddr = 3'd2; IN = 16'h2222;
    tick();
    wAddr = 3'd6; IN = 16'h6666;
    tick();
    writeEn = 1'b0; rAddrA = 3'd6; rAddrB = 3'd2; clearReq = 1'b1;
    exp_nx("rs_k", 16'h6666, 16'h2222, 1'b1);
    tick();
    clearReq = 1'b0;
    exp_nx("rs_k1", 16'h6666, 16'h2222, 1'b1);
    tick();
    exp_nx("rs_k2", 16'h6666, BYP ? 16'h0000 : 16'h2222, 1'b1);
    tick();
    async_reset_check("rs_abort");
    tick();
    reset = 1'b1;
    read_all_zero("rs_rd_all");
    writeEn = 1'b1; wAddr = 3'd3; IN = 16'h5A5A;
    tick();
    writeEn = 1'b0; rAddrA = 3'd3; rAddrB = 3'd6;
    exp_nx("rs_wr", 16'h5A5A, 16'h0000, 1'b0);
    tick();

    @(negedge CLK);
    #1;
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %0s expectation never checked want_edge=%0d", sb[0].nm, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
